// File: rtl/vector_permute_unit_pkg.sv
// vector_permute_unit_pkg: op/size encodings and helpers shared by the permute datapath
package vector_permute_unit_pkg;
  typedef enum logic [2:0] {
    PERMUTE_PACK   = 3'd0,
    PERMUTE_SPLAT  = 3'd1,
    PERMUTE_SPLATB = 3'd2,
    PERMUTE_SHIFT  = 3'd3,
    PERMUTE_SHIFTB = 3'd4,
    PERMUTE_SELECT = 3'd5
  } permute_op_e;
  typedef enum logic {
    PERMUTE_HALFWORD = 1'b0,
    PERMUTE_BYTE     = 1'b1
  } permute_size_e;
  localparam int PERMUTE_BYTES_PER_ELEM = 2;
  function automatic logic [7:0] sat_s16_to_s8(input logic [15:0] x);
    return ($signed(x) > 16'sd127) ? 8'h7f : ($signed(x) < -16'sd128) ? 8'h80 : x[7:0];
  endfunction
endpackage

// File: rtl/vector_permute_unit_shifter.sv
// vector_permute_unit_shifter: lane shift by a signed amount, positive moves lanes up, zero fill
module vector_permute_unit_shifter #(
  parameter int NUM_LANES = 8,
  parameter int LANE_SIZE = 16
) (
  input  logic [NUM_LANES*LANE_SIZE-1:0] data,
  input  logic signed [4:0]              amt,
  output logic [NUM_LANES*LANE_SIZE-1:0] shifted
);
  logic [4:0] mag;
  assign mag = amt[4] ? 5'(-amt) : amt;
  assign shifted = amt[4] ? (data >> (int'(mag) * LANE_SIZE)) : (data << (int'(mag) * LANE_SIZE));
endmodule

// File: rtl/vector_permute_unit.sv
// vector_permute_unit: 2-stage pack/unpack/splat/shift/select datapath; VECTOR_PERMUTE_SAT_PACK_EN makes pack_lower saturate
module vector_permute_unit
  import vector_permute_unit_pkg::*;
#(
  parameter int NUM_ELEMS = 8,
  parameter int ELEM_SIZE = 16,
  localparam int W  = NUM_ELEMS * ELEM_SIZE,
  localparam int GW = (2 * NUM_ELEMS > 16) ? 2 * NUM_ELEMS : 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    op,
  input  logic          pack_upper,
  input  logic          pack_lower,
  input  logic          unpack_left,
  input  logic          unpack_right,
  input  logic [GW-1:0] g,
  input  logic          size,
  input  logic [4:0]    shift,
  input  logic          keep_res,
  input  logic          in_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  res,
  output logic          res_valid
);
  localparam int NB = NUM_ELEMS * PERMUTE_BYTES_PER_ELEM;
  permute_op_e       op_q;
  logic [3:0]        flags_q;
  logic [GW-1:0]     g_q;
  logic              size_q;
  logic signed [4:0] shift_q;
  logic [W-1:0]      a_q, b_q;
  logic              v_q;
  logic [W-1:0]      pack_v, unpl_v, unpr_v, selh_v, selb_v, splat_v, splatb_v, sh_hw, sh_b, res_d;

  function automatic logic [7:0] pack_lo(input logic [15:0] x);
`ifdef VECTOR_PERMUTE_SAT_PACK_EN
    return sat_s16_to_s8(x);
`else
    return x[7:0];
`endif
  endfunction

  // stage 1: capture operands, control fields and valid when the pipe advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= PERMUTE_PACK;
      flags_q <= '0;
      g_q     <= '0;
      size_q  <= 1'b0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v_q     <= 1'b0;
    end else if (keep_res) begin
      op_q    <= permute_op_e'(op);
      flags_q <= {pack_upper, pack_lower, unpack_left, unpack_right};
      g_q     <= g;
      size_q  <= size;
      shift_q <= shift;
      a_q     <= a;
      b_q     <= b;
      v_q     <= in_valid;
    end
  end

  vector_permute_unit_shifter #(.NUM_LANES(NUM_ELEMS), .LANE_SIZE(ELEM_SIZE)) u_sh_hw (
    .data(a_q), .amt(shift_q), .shifted(sh_hw)
  );
  vector_permute_unit_shifter #(.NUM_LANES(NB), .LANE_SIZE(8)) u_sh_b (
    .data(a_q), .amt(shift_q), .shifted(sh_b)
  );

  // per-element candidates for pack/unpack, select and splat
  always_comb begin
    pack_v   = '0;
    unpl_v   = '0;
    unpr_v   = '0;
    selh_v   = '0;
    selb_v   = '0;
    splat_v  = '0;
    splatb_v = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      pack_v[8*i +: 8]             = flags_q[3] ? a_q[16*i+8 +: 8] : pack_lo(a_q[16*i +: 16]);
      pack_v[8*(NUM_ELEMS+i) +: 8] = flags_q[3] ? b_q[16*i+8 +: 8] : pack_lo(b_q[16*i +: 16]);
      unpl_v[16*i +: 16]           = {8'h00, a_q[8*i +: 8]};
      unpr_v[16*i +: 16]           = {8'h00, a_q[8*(NUM_ELEMS+i) +: 8]};
      selh_v[16*i +: 16]           = g_q[i] ? a_q[16*i +: 16] : b_q[16*i +: 16];
      splat_v[16*i +: 16]          = g_q[15:0];
    end
    for (int j = 0; j < NB; j++) begin
      selb_v[8*j +: 8]   = g_q[j] ? a_q[8*j +: 8] : b_q[8*j +: 8];
      splatb_v[8*j +: 8] = g_q[7:0];
    end
  end

  // op mux; pack flags resolve by priority upper > lower > left > right, none set is a move
  always_comb begin
    res_d = op_q == PERMUTE_SPLAT  ? splat_v :
            op_q == PERMUTE_SPLATB ? splatb_v :
            op_q == PERMUTE_SHIFT  ? sh_hw :
            op_q == PERMUTE_SHIFTB ? sh_b :
            op_q == PERMUTE_SELECT ? (size_q == PERMUTE_BYTE ? selb_v : selh_v) :
            op_q == PERMUTE_PACK   ? ((flags_q[3] | flags_q[2]) ? pack_v :
                                      flags_q[1] ? unpl_v : flags_q[0] ? unpr_v : a_q) :
            '0;
  end

  // stage 2: result register, frozen together with stage 1 while keep_res is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res       <= '0;
      res_valid <= 1'b0;
    end else if (keep_res) begin
      res       <= res_d;
      res_valid <= v_q;
    end
  end

  a_flags_onehot: assert property (@(posedge clk) disable iff (reset)
    (in_valid && keep_res) |-> $onehot0({pack_upper, pack_lower, unpack_left, unpack_right}));
  a_valid_stable: assert property (@(posedge clk) disable iff (reset)
    !keep_res |=> (keep_res || $stable(in_valid)));
endmodule
